// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit.
package bru_pkg;

    localparam int unsigned BRU_XLEN = 32;
    localparam int unsigned BRU_PC_W = BRU_XLEN - 2;

    localparam logic [1:0] BT_COND = 2'b00;
    localparam logic [1:0] BT_CALL = 2'b01;
    localparam logic [1:0] BT_JUMP = 2'b10;
    localparam logic [1:0] BT_RET  = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Taken selector formed from {funct3[2], funct3[0]}
    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_NE = 2'b01,
        CMP_LT = 2'b10,
        CMP_GE = 2'b11
    } cmp_sel_e;

    typedef struct packed {
        logic [BRU_PC_W-1:0] pc;
        logic [BRU_XLEN-1:0] target;
        logic [1:0]          cntr;
        logic [1:0]          btype;
        logic                tkn;
        logic                way;
        logic                bm_mod;
        logic                call;
        logic                ret;
    } btb_upd_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue, writeback, completion and BTB-training bus of the branch resolution unit.
// Optional perf counter signals exist only when BRU_PERF_CNT_EN is defined.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ROB_W = 6,
    parameter int unsigned PRF_W = 6
);
    localparam int unsigned PC_W = XLEN - 2;

    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [XLEN-1:0]  operand_1;
    logic [XLEN-1:0]  operand_2;
    logic [XLEN-1:0]  offset;
    logic [PC_W-1:0]  pc;
    logic             auipc;
    logic             call;
    logic             ret;
    logic             jal;
    logic             jalr;
    logic [2:0]       bnch_cond;
    logic [ROB_W-1:0] rob_id_i;
    logic [PRF_W-1:0] dest_i;
    logic [1:0]       bm_pred_i;
    logic [1:0]       btype_i;
    logic             btb_vld_i;
    logic             btb_way_i;
    logic [PC_W-1:0]  btb_target_i;

    logic [XLEN-1:0]  result_o;
    logic             wb_valid_o;
    logic [PRF_W-1:0] wb_dest_o;
    logic             res_valid_o;
    logic [ROB_W-1:0] rob_o;
    logic             rcu_excp_o;
    logic [XLEN-1:0]  redirect_pc_o;

    logic             upd_valid_o;
    logic             upd_ready_i;
    logic [PC_W-1:0]  upd_pc_o;
    logic [XLEN-1:0]  upd_target_o;
    logic [1:0]       upd_cntr_o;
    logic [1:0]       upd_type_o;
    logic             upd_tkn_o;
    logic             upd_way_o;
    logic             upd_bm_mod_o;
    logic             upd_call_o;
    logic             upd_ret_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]      perf_branches_o;
    logic [31:0]      perf_mispred_o;
`endif

    modport slave (
        input  flush_i, valid_i, operand_1, operand_2, offset, pc,
               auipc, call, ret, jal, jalr, bnch_cond, rob_id_i, dest_i,
               bm_pred_i, btype_i, btb_vld_i, btb_way_i, btb_target_i, upd_ready_i,
        output ready_o, result_o, wb_valid_o, wb_dest_o, res_valid_o, rob_o,
               rcu_excp_o, redirect_pc_o, upd_valid_o, upd_pc_o, upd_target_o,
               upd_cntr_o, upd_type_o, upd_tkn_o, upd_way_o, upd_bm_mod_o,
               upd_call_o, upd_ret_o
`ifdef BRU_PERF_CNT_EN
        , output perf_branches_o, perf_mispred_o
`endif
    );

    modport master (
        output flush_i, valid_i, operand_1, operand_2, offset, pc,
               auipc, call, ret, jal, jalr, bnch_cond, rob_id_i, dest_i,
               bm_pred_i, btype_i, btb_vld_i, btb_way_i, btb_target_i, upd_ready_i,
        input  ready_o, result_o, wb_valid_o, wb_dest_o, res_valid_o, rob_o,
               rcu_excp_o, redirect_pc_o, upd_valid_o, upd_pc_o, upd_target_o,
               upd_cntr_o, upd_type_o, upd_tkn_o, upd_way_o, upd_bm_mod_o,
               upd_call_o, upd_ret_o
`ifdef BRU_PERF_CNT_EN
        , input perf_branches_o, perf_mispred_o
`endif
    );

endinterface

// File: rtl/bru_upd_fifo.sv
// Synchronous FIFO for BTB training records; head entry is presented straight from storage.
module bru_upd_fifo
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = btb_upd_t
) (
    input  logic   cpu_clock_i,
    input  logic   cpu_reset_i,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head_c,
    output logic   full_c,
    output logic   empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign head_c  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty_c) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (push && !full_c) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: condition evaluation, BTB prediction check, link/AUIPC writeback,
// and buffered BTB training. Define BRU_PERF_CNT_EN to add branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned XLEN       = BRU_XLEN,
    parameter int unsigned ROB_W      = 6,
    parameter int unsigned PRF_W      = 6,
    parameter int unsigned UPDQ_DEPTH = 4
) (
    input logic                   cpu_clock_i,
    input logic                   cpu_reset_i,
    branch_resolve_unit_if.slave  bus
);
    localparam int unsigned PC_W = XLEN - 2;

    logic            accept_c;
    logic            push_c;
    logic            queue_full_c;
    logic            queue_empty_c;
    logic            jump_c;
    logic            eq_c;
    logic            gt_c;
    logic            lt_c;
    logic            cond_taken_c;
    logic            taken_c;
    logic            tgt_miss_c;
    logic            type_miss_c;
    logic            dir_miss_c;
    logic            mispred_c;
    logic [1:0]      btype_c;
    logic [XLEN-1:0] pc_byte_c;
    logic [XLEN-1:0] base_c;
    logic [XLEN-1:0] next_pc_c;
    logic [XLEN-1:0] result_c;
    btb_upd_t        push_entry_c;
    btb_upd_t        head_c;

    // Resolve direction, target and prediction outcome of the incoming op
    always_comb begin
        cond_taken_c = 1'b0;
        btype_c      = BT_COND;
        push_entry_c = '0;

        jump_c = bus.jal | bus.jalr;
        eq_c   = (bus.operand_1 == bus.operand_2);
        gt_c   = bus.bnch_cond[1] ? (bus.operand_1 > bus.operand_2)
                                  : ($signed(bus.operand_1) > $signed(bus.operand_2));
        lt_c   = !(gt_c | eq_c);

        case ({bus.bnch_cond[2], bus.bnch_cond[0]})
            CMP_EQ:  cond_taken_c = eq_c;
            CMP_NE:  cond_taken_c = !eq_c;
            CMP_LT:  cond_taken_c = lt_c;
            CMP_GE:  cond_taken_c = !lt_c;
            default: cond_taken_c = 1'b0;
        endcase
        taken_c = jump_c | (!bus.auipc & cond_taken_c);

        if (bus.call)      btype_c = BT_CALL;
        else if (bus.ret)  btype_c = BT_RET;
        else if (jump_c)   btype_c = BT_JUMP;

        pc_byte_c = {bus.pc, 2'b00};
        base_c    = bus.jalr ? bus.operand_1 : pc_byte_c;
        next_pc_c = base_c + ((taken_c & !bus.auipc) ? bus.offset : XLEN'(4));
        result_c  = bus.auipc ? (pc_byte_c + bus.offset) : (pc_byte_c + XLEN'(4));

        tgt_miss_c  = (bus.btb_target_i != next_pc_c[XLEN-1:2]);
        type_miss_c = (bus.btype_i != btype_c);
        dir_miss_c  = (btype_c == BT_COND) & (taken_c != bus.bm_pred_i[1]);
        mispred_c   = !bus.auipc & (bus.btb_vld_i ? (tgt_miss_c | type_miss_c | dir_miss_c)
                                                  : taken_c);

        accept_c = bus.valid_i & !queue_full_c & !bus.flush_i;
        push_c   = accept_c & !bus.auipc & (taken_c | bus.btb_vld_i);

        push_entry_c.pc     = bus.pc;
        push_entry_c.target = next_pc_c;
        push_entry_c.cntr   = bus.bm_pred_i;
        push_entry_c.btype  = btype_c;
        push_entry_c.tkn    = taken_c;
        push_entry_c.way    = bus.btb_way_i;
        push_entry_c.bm_mod = bus.btb_vld_i & !mispred_c & !bus.call & !bus.ret;
        push_entry_c.call   = bus.call & !mispred_c;
        push_entry_c.ret    = bus.ret & !mispred_c;
    end

    // Stage-1 result registers
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            bus.res_valid_o   <= 1'b0;
            bus.wb_valid_o    <= 1'b0;
            bus.rcu_excp_o    <= 1'b0;
            bus.result_o      <= '0;
            bus.redirect_pc_o <= '0;
            bus.wb_dest_o     <= '0;
            bus.rob_o         <= '0;
        end else begin
            bus.res_valid_o <= accept_c;
            bus.wb_valid_o  <= accept_c & (bus.auipc | jump_c) & (bus.dest_i != '0);
            bus.rcu_excp_o  <= accept_c & mispred_c;
            if (accept_c) begin
                bus.result_o      <= result_c;
                bus.redirect_pc_o <= next_pc_c;
                bus.wb_dest_o     <= bus.dest_i;
                bus.rob_o         <= bus.rob_id_i;
            end
        end
    end

    bru_upd_fifo #(
        .DEPTH   (UPDQ_DEPTH),
        .entry_t (btb_upd_t)
    ) u_upd_fifo (
        .cpu_clock_i (cpu_clock_i),
        .cpu_reset_i (cpu_reset_i),
        .push        (push_c),
        .push_data   (push_entry_c),
        .pop         (bus.upd_valid_o & bus.upd_ready_i),
        .head_c      (head_c),
        .full_c      (queue_full_c),
        .empty_c     (queue_empty_c)
    );

    assign bus.ready_o      = !queue_full_c;
    assign bus.upd_valid_o  = !queue_empty_c;
    assign bus.upd_pc_o     = head_c.pc;
    assign bus.upd_target_o = head_c.target;
    assign bus.upd_cntr_o   = head_c.cntr;
    assign bus.upd_type_o   = head_c.btype;
    assign bus.upd_tkn_o    = head_c.tkn;
    assign bus.upd_way_o    = head_c.way;
    assign bus.upd_bm_mod_o = head_c.bm_mod;
    assign bus.upd_call_o   = head_c.call;
    assign bus.upd_ret_o    = head_c.ret;

`ifdef BRU_PERF_CNT_EN
    // Mispredicts are counted on the same edge that raises rcu_excp_o
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            bus.perf_branches_o <= '0;
            bus.perf_mispred_o  <= '0;
        end else begin
            if (accept_c & !bus.auipc) bus.perf_branches_o <= bus.perf_branches_o + 32'(1);
            if (accept_c & mispred_c)  bus.perf_mispred_o  <= bus.perf_mispred_o + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stage-1 results and training records.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ROB_W = 6;
    localparam int unsigned PRF_W = 6;

    typedef struct packed {
        logic [31:0] a, b, off;
        logic [29:0] pc;
        logic        auipc, call, ret, jal, jalr;
        logic [2:0]  cond;
        logic [5:0]  rob, dest;
        logic [1:0]  bm, btype;
        logic        bv, bway;
        logic [29:0] btgt;
    } op_t;

    typedef struct {
        logic        resv, excp, wbv;
        logic [31:0] redir, result;
        logic [5:0]  rob, dest;
    } s1_exp_t;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] target;
        logic [1:0]  cntr, btype;
        logic        tkn, way, bm_mod, call, ret;
    } upd_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;
    s1_exp_t  s1_q[$];
    upd_exp_t upd_q[$];
    s1_exp_t  s1_chk;
    upd_exp_t upd_chk;
    upd_exp_t upd_got;
    logic     s1_sampled;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XLEN), .ROB_W(ROB_W), .PRF_W(PRF_W)) bus ();

    branch_resolve_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .PRF_W(PRF_W), .UPDQ_DEPTH(4)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    function automatic void model(input op_t o, output s1_exp_t s, output logic push,
                                  output upd_exp_t u);
        logic taken, mis;
        logic [31:0] pcb, npc;
        logic [1:0] ty;
        case (o.cond)
            F3_BEQ:  taken = (o.a == o.b);
            F3_BNE:  taken = (o.a != o.b);
            F3_BLT:  taken = ($signed(o.a) < $signed(o.b));
            F3_BGE:  taken = ($signed(o.a) >= $signed(o.b));
            F3_BLTU: taken = (o.a < o.b);
            F3_BGEU: taken = (o.a >= o.b);
            default: taken = 1'b0;
        endcase
        if (o.auipc) taken = 1'b0;
        if (o.jal || o.jalr) taken = 1'b1;
        ty  = o.call ? BT_CALL : o.ret ? BT_RET : (o.jal || o.jalr) ? BT_JUMP : BT_COND;
        pcb = {o.pc, 2'b00};
        npc = (o.jalr ? o.a : pcb) + (taken ? o.off : 32'd4);
        if (o.auipc) mis = 1'b0;
        else if (!o.bv) mis = taken;
        else mis = (o.btgt != npc[31:2]) || (o.btype != ty) || (ty == BT_COND && taken != o.bm[1]);
        s.resv   = 1'b1;
        s.excp   = mis;
        s.redir  = npc;
        s.wbv    = (o.auipc || o.jal || o.jalr) && (o.dest != 6'd0);
        s.result = o.auipc ? pcb + o.off : pcb + 32'd4;
        s.rob    = o.rob;
        s.dest   = o.dest;
        push = !o.auipc && (taken || o.bv);
        u = '{pc: o.pc, target: npc, cntr: o.bm, btype: ty, tkn: taken, way: o.bway,
              bm_mod: o.bv && !mis && !o.call && !o.ret,
              call: o.call && !mis, ret: o.ret && !mis};
    endfunction

    function automatic op_t mk_br(input logic [2:0] cond, input logic [31:0] a, b,
                                  input logic [29:0] pc, input logic [31:0] off);
        op_t o = '0;
        o.cond = cond; o.a = a; o.b = b; o.pc = pc; o.off = off;
        return o;
    endfunction

    task automatic drive(input op_t o, input logic flush, input logic exp_rdy);
        s1_exp_t s;
        logic p;
        upd_exp_t u;
        @(negedge clk);
        bus.operand_1 = o.a; bus.operand_2 = o.b; bus.offset = o.off; bus.pc = o.pc;
        bus.auipc = o.auipc; bus.call = o.call; bus.ret = o.ret; bus.jal = o.jal;
        bus.jalr = o.jalr; bus.bnch_cond = o.cond; bus.rob_id_i = o.rob; bus.dest_i = o.dest;
        bus.bm_pred_i = o.bm; bus.btype_i = o.btype; bus.btb_vld_i = o.bv;
        bus.btb_way_i = o.bway; bus.btb_target_i = o.btgt;
        bus.valid_i = 1'b1; bus.flush_i = flush;
        model(o, s, p, u);
        if (!exp_rdy || flush) begin
            s.resv = 1'b0; s.excp = 1'b0; s.wbv = 1'b0;
        end else if (p) begin
            upd_q.push_back(u);
        end
        s1_q.push_back(s);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic set_upd_ready(input logic v);
        @(posedge clk);
        #2 bus.upd_ready_i = v;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && upd_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (upd_q.size() != 0 || bus.upd_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: pending=%0d upd_valid=%b, required pending=0 upd_valid=0",
                     upd_q.size(), bus.upd_valid_o);
        end
    endtask

    // Stage-1 scoreboard: every cycle with valid_i driven has one expectation
    always @(posedge clk) begin
        s1_sampled = bus.valid_i && !rst;
        #1;
        if (s1_sampled) begin
            tests_run++;
            if (s1_q.size() == 0) begin
                tests_failed++;
                $display("FAIL s1_unexpected: no expectation queued");
            end else begin
                s1_chk = s1_q.pop_front();
                if ({bus.res_valid_o, bus.rcu_excp_o, bus.wb_valid_o} !==
                    {s1_chk.resv, s1_chk.excp, s1_chk.wbv}) begin
                    tests_failed++;
                    $display("FAIL s1_flags: got res/excp/wb=%b%b%b required %b%b%b",
                             bus.res_valid_o, bus.rcu_excp_o, bus.wb_valid_o,
                             s1_chk.resv, s1_chk.excp, s1_chk.wbv);
                end
                if (s1_chk.resv && bus.rob_o !== s1_chk.rob) begin
                    tests_failed++;
                    $display("FAIL s1_rob: got %h required %h", bus.rob_o, s1_chk.rob);
                end
                if (s1_chk.excp && bus.redirect_pc_o !== s1_chk.redir) begin
                    tests_failed++;
                    $display("FAIL s1_redirect: got %h required %h", bus.redirect_pc_o, s1_chk.redir);
                end
                if (s1_chk.wbv && {bus.result_o, bus.wb_dest_o} !== {s1_chk.result, s1_chk.dest}) begin
                    tests_failed++;
                    $display("FAIL s1_wb: got %h/%h required %h/%h", bus.result_o, bus.wb_dest_o,
                             s1_chk.result, s1_chk.dest);
                end
            end
        end
    end

    // Training scoreboard: compare on each handshake, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && bus.upd_valid_o === 1'b1 && bus.upd_ready_i === 1'b1) begin
            tests_run++;
            if (upd_q.size() == 0) begin
                tests_failed++;
                $display("FAIL upd_unexpected: pc=%h target=%h", bus.upd_pc_o, bus.upd_target_o);
            end else begin
                upd_chk = upd_q.pop_front();
                upd_got = '{pc: bus.upd_pc_o, target: bus.upd_target_o, cntr: bus.upd_cntr_o,
                            btype: bus.upd_type_o, tkn: bus.upd_tkn_o, way: bus.upd_way_o,
                            bm_mod: bus.upd_bm_mod_o, call: bus.upd_call_o, ret: bus.upd_ret_o};
                if (upd_got !== upd_chk) begin
                    tests_failed++;
                    $display("FAIL upd_entry: got %h required %h", upd_got, upd_chk);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.res_valid_o, bus.wb_valid_o, bus.rcu_excp_o, bus.upd_valid_o, bus.ready_o} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b%b%b%b%b required 00001", bus.res_valid_o,
                     bus.wb_valid_o, bus.rcu_excp_o, bus.upd_valid_o, bus.ready_o);
        end
        tests_run++;
        if ({bus.result_o, bus.redirect_pc_o, bus.wb_dest_o, bus.rob_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h %h %h %h required zeros", bus.result_o,
                     bus.redirect_pc_o, bus.wb_dest_o, bus.rob_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_beq_hit();
        op_t o = mk_br(F3_BEQ, 32'd5, 32'd5, 30'h100, 32'h40);
        set_upd_ready(1'b1);
        o.bv = 1'b1; o.btgt = 30'h110; o.btype = BT_COND; o.bm = 2'b11; o.rob = 6'd1;
        drive(o, 1'b0, 1'b1);
        idle();
        tests_run++;
        if ({bus.rcu_excp_o, bus.upd_valid_o, bus.upd_tkn_o, bus.upd_bm_mod_o} !== 4'b0111 ||
            bus.upd_target_o !== 32'h0000_0440) begin
            tests_failed++;
            $display("FAIL beq_hit: excp=%b uv=%b tkn=%b bm=%b tgt=%h required 0 1 1 1 00000440",
                     bus.rcu_excp_o, bus.upd_valid_o, bus.upd_tkn_o, bus.upd_bm_mod_o, bus.upd_target_o);
        end
        wait_drain();
    endtask

    task automatic test_blt_signed();
        op_t o = mk_br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 30'h40, 32'h80);
        o.rob = 6'd2;
        drive(o, 1'b0, 1'b1);
        idle();
        tests_run++;
        if (bus.rcu_excp_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_0180) begin
            tests_failed++;
            $display("FAIL blt: excp=%b redirect=%h required 1 00000180",
                     bus.rcu_excp_o, bus.redirect_pc_o);
        end
        o.cond = F3_BLTU; o.rob = 6'd3;
        drive(o, 1'b0, 1'b1);
        idle();
        tests_run++;
        if ({bus.res_valid_o, bus.rcu_excp_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bltu: res/excp=%b%b required 10", bus.res_valid_o, bus.rcu_excp_o);
        end
        wait_drain();
    endtask

    task automatic test_jal();
        op_t o = mk_br(3'b000, 32'd0, 32'd0, 30'h200, 32'h10);
        o.jal = 1'b1; o.dest = 6'd5; o.rob = 6'd4;
        drive(o, 1'b0, 1'b1);
        idle();
        tests_run++;
        if (bus.wb_valid_o !== 1'b1 || bus.result_o !== 32'h0000_0804 || bus.wb_dest_o !== 6'd5) begin
            tests_failed++;
            $display("FAIL jal_link: wb=%b result=%h dest=%0d required 1 00000804 5",
                     bus.wb_valid_o, bus.result_o, bus.wb_dest_o);
        end
        o.dest = 6'd0;
        drive(o, 1'b0, 1'b1);
        idle();
        tests_run++;
        if (bus.wb_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL jal_x0: wb=%b required 0", bus.wb_valid_o);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back_full();
        op_t o;
        set_upd_ready(1'b0);
        for (int k = 0; k < 4; k++) begin
            o = mk_br(F3_BNE, 32'(k), 32'(k + 1), 30'(32'h300 + k), 32'h20);
            o.bv = 1'b1; o.btgt = 30'(32'h308 + k); o.bm = 2'b11; o.bway = k[0]; o.rob = 6'(k);
            drive(o, 1'b0, 1'b1);
        end
        idle();
        tests_run++;
        if ({bus.ready_o, bus.upd_valid_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL full_ready: ready=%b uv=%b required 0 1", bus.ready_o, bus.upd_valid_o);
        end
        o = mk_br(F3_BEQ, 32'd7, 32'd7, 30'h3F0, 32'h8);
        drive(o, 1'b0, 1'b0);
        idle();
        tests_run++;
        if (bus.ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_hold: ready=%b required 0", bus.ready_o);
        end
        set_upd_ready(1'b1);
        wait_drain();
        tests_run++;
        if (bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_ready: ready=%b required 1", bus.ready_o);
        end
    endtask

    task automatic test_flush();
        op_t o;
        set_upd_ready(1'b0);
        for (int k = 0; k < 2; k++) begin
            o = mk_br(F3_BGE, 32'd9, 32'(k), 30'(32'h500 + k), 32'h40);
            o.rob = 6'(10 + k);
            drive(o, 1'b0, 1'b1);
        end
        o = mk_br(F3_BEQ, 32'd1, 32'd1, 30'h600, 32'h100);
        drive(o, 1'b1, 1'b1);
        idle();
        tests_run++;
        if ({bus.res_valid_o, bus.rcu_excp_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush: res/excp=%b%b required 00", bus.res_valid_o, bus.rcu_excp_o);
        end
        set_upd_ready(1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid_drain();
        op_t o;
        set_upd_ready(1'b0);
        for (int k = 0; k < 2; k++) begin
            o = mk_br(F3_BLTU, 32'd1, 32'd2, 30'(32'h700 + k), 32'h4);
            drive(o, 1'b0, 1'b1);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        upd_q.delete();
        @(negedge clk);
        tests_run++;
        if ({bus.upd_valid_o, bus.res_valid_o, bus.wb_valid_o, bus.rcu_excp_o, bus.ready_o} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_mid: uv/res/wb/excp/ready=%b%b%b%b%b required 00001", bus.upd_valid_o,
                     bus.res_valid_o, bus.wb_valid_o, bus.rcu_excp_o, bus.ready_o);
        end
        rst = 1'b0;
        set_upd_ready(1'b1);
        repeat (3) @(posedge clk);
        wait_drain();
    endtask

    task automatic test_random();
        op_t o;
        s1_exp_t s;
        logic p;
        upd_exp_t u;
        logic [2:0] conds [6] = '{F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
        int kind;
        set_upd_ready(1'b1);
        for (int n = 0; n < 60; n++) begin
            o = '0;
            kind   = $urandom_range(0, 5);
            o.cond = conds[$urandom_range(0, 5)];
            o.a    = $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 3));
            o.b    = $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 3));
            o.pc   = 30'($urandom);
            o.off  = 32'($urandom_range(0, 1023)) << 2;
            o.jal  = (kind == 1 || kind == 3);
            o.jalr = (kind == 2 || kind == 4);
            o.call = (kind == 3);
            o.ret  = (kind == 4);
            o.auipc = (kind == 5);
            o.dest = 6'($urandom_range(0, 7));
            o.rob  = 6'($urandom);
            o.bv   = 1'($urandom);
            o.bway = 1'($urandom);
            o.bm   = 2'($urandom);
            o.btype = 2'($urandom);
            o.btgt = 30'($urandom);
            model(o, s, p, u);
            if ($urandom_range(0, 1) == 1) begin
                o.btgt  = s.redir[31:2];
                o.btype = u.btype;
            end
            drive(o, 1'b0, 1'b1);
        end
        idle();
        wait_drain();
    endtask

    initial begin
        rst = 1'b1;
        bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.upd_ready_i = 1'b0;
        bus.operand_1 = '0; bus.operand_2 = '0; bus.offset = '0; bus.pc = '0;
        bus.auipc = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jal = 1'b0; bus.jalr = 1'b0;
        bus.bnch_cond = '0; bus.rob_id_i = '0; bus.dest_i = '0; bus.bm_pred_i = '0;
        bus.btype_i = '0; bus.btb_vld_i = 1'b0; bus.btb_way_i = 1'b0; bus.btb_target_i = '0;
        test_reset();
        test_beq_hit();
        test_blt_signed();
        test_jal();
        test_back_to_back_full();
        test_flush();
        test_reset_mid_drain();
        test_random();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
